// File: rtl/alu_ctrl.sv
// Multicycle execute controller: decodes MIPS ALU/branch ops, sequences the ALU, returns results.
// Optional signed-overflow trapping on ADD/ADDI/SUB when ALU_CTRL_TRAP_EN is defined.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_z,
  input  logic        alu_overflow,
  input  logic        alu_equal,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        out_wr,
  output logic        out_branch_taken,
  output logic        out_illegal,
  output logic        out_trap
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rt_f, rd_f;
  logic [31:0] imm_s, imm_z;

  logic [31:0] dec_x, dec_y;
  logic [3:0]  dec_op;
  logic [4:0]  dec_dest;
  logic        dec_br, dec_bne, dec_ill, dec_trap_ok;

  logic [31:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [4:0]  dest_q, dest_d;
  logic        br_q, br_d, bne_q, bne_d;
  logic        ill_q, ill_d, trap_ok_q, trap_ok_d;

  logic [31:0] res_q, res_d;
  logic [4:0]  odest_q, odest_d;
  logic        wr_q, wr_d, taken_q, taken_d;
  logic        oill_q, oill_d, trap_q, trap_d;
  logic        trap_fire;

  logic unused;
  assign unused = ^{alu_zero, alu_overflow, instr[25:21]};

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm_s  = {{16{instr[15]}}, instr[15:0]};
  assign imm_z  = {16'b0, instr[15:0]};

  always_comb begin
    dec_x       = rs_data;
    dec_y       = rt_data;
    dec_op      = OP_NONE;
    dec_dest    = rd_f;
    dec_br      = 1'b0;
    dec_bne     = 1'b0;
    dec_ill     = 1'b0;
    dec_trap_ok = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h26: dec_op = OP_XOR;
          6'h27: dec_op = OP_NOR;
          6'h20: begin dec_op = OP_ADD; dec_trap_ok = 1'b1; end
          6'h21: dec_op = OP_ADD;
          6'h22: begin dec_op = OP_SUB; dec_trap_ok = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h2A: dec_op = OP_SLT;
          6'h00: begin dec_op = OP_SLL; dec_x = {27'b0, shamt}; end
          6'h02: begin dec_op = OP_SRL; dec_x = {27'b0, shamt}; end
          6'h03: begin dec_op = OP_SRA; dec_x = {27'b0, shamt}; end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin dec_op = OP_ADD; dec_y = imm_s; dec_trap_ok = 1'b1; end
      6'h09: begin dec_op = OP_ADD; dec_y = imm_s; end
      6'h0A: begin dec_op = OP_SLT; dec_y = imm_s; end
      6'h0C: begin dec_op = OP_AND; dec_y = imm_z; end
      6'h0D: begin dec_op = OP_OR;  dec_y = imm_z; end
      6'h0E: begin dec_op = OP_XOR; dec_y = imm_z; end
      6'h04: begin dec_op = OP_SUB; dec_br = 1'b1; end
      6'h05: begin dec_op = OP_SUB; dec_br = 1'b1; dec_bne = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
    if (opcode != 6'h00) dec_dest = rt_f;
    if (dec_ill) dec_op = OP_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
  end

  assign accept = in_valid & in_ready;

`ifdef ALU_CTRL_TRAP_EN
  assign trap_fire = trap_ok_q & alu_overflow;
`else
  assign trap_fire = 1'b0;
`endif

  always_comb begin
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    alu_op_d  = alu_op_q;
    dest_d    = dest_q;
    br_d      = br_q;
    bne_d     = bne_q;
    ill_d     = ill_q;
    trap_ok_d = trap_ok_q;
    res_d     = res_q;
    odest_d   = odest_q;
    wr_d      = wr_q;
    taken_d   = taken_q;
    oill_d    = oill_q;
    trap_d    = trap_q;
    if (accept) begin
      alu_x_d   = dec_x;
      alu_y_d   = dec_y;
      alu_op_d  = dec_op;
      dest_d    = dec_dest;
      br_d      = dec_br;
      bne_d     = dec_bne;
      ill_d     = dec_ill;
      trap_ok_d = dec_trap_ok;
    end
    if (state_q == S_EXEC) begin
      res_d   = ill_q ? 32'b0 : alu_z;
      odest_d = dest_q;
      wr_d    = ~ill_q & ~br_q & ~trap_fire;
      taken_d = br_q & (alu_equal ^ bne_q);
      oill_d  = ill_q;
      trap_d  = trap_fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      alu_op_q  <= OP_NONE;
      dest_q    <= '0;
      br_q      <= 1'b0;
      bne_q     <= 1'b0;
      ill_q     <= 1'b0;
      trap_ok_q <= 1'b0;
      res_q     <= '0;
      odest_q   <= '0;
      wr_q      <= 1'b0;
      taken_q   <= 1'b0;
      oill_q    <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      alu_op_q  <= alu_op_d;
      dest_q    <= dest_d;
      br_q      <= br_d;
      bne_q     <= bne_d;
      ill_q     <= ill_d;
      trap_ok_q <= trap_ok_d;
      res_q     <= res_d;
      odest_q   <= odest_d;
      wr_q      <= wr_d;
      taken_q   <= taken_d;
      oill_q    <= oill_d;
      trap_q    <= trap_d;
    end
  end

  assign alu_x            = alu_x_q;
  assign alu_y            = alu_y_q;
  assign alu_op           = alu_op_q;
  assign out_result       = res_q;
  assign out_dest         = odest_q;
  assign out_wr           = wr_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = oill_q;
  assign out_trap         = trap_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU on the far side, instruction-level reference model,
// directed vectors with literal results.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] alu_x, alu_y;
  logic [3:0]  alu_op;
  logic [31:0] alu_z;
  logic        alu_overflow, alu_equal, alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wr, out_branch_taken, out_illegal, out_trap;

  int n_cmp = 0;
  int n_bad = 0;

  alu_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_z(alu_z), .alu_overflow(alu_overflow),
    .alu_equal(alu_equal), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_wr(out_wr),
    .out_branch_taken(out_branch_taken),
    .out_illegal(out_illegal), .out_trap(out_trap)
  );

  always #5 clk = ~clk;

  // Combinational ALU standing in for the real alu block
  always_comb begin
    longint s;
    s = 0;
    alu_z = 32'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'd0: alu_z = alu_x & alu_y;
      4'd1: alu_z = alu_x | alu_y;
      4'd2: alu_z = alu_x ^ alu_y;
      4'd3: alu_z = ~(alu_x | alu_y);
      4'd5: begin
        s = longint'($signed(alu_x)) + longint'($signed(alu_y));
        alu_z = alu_x + alu_y;
        alu_overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s = longint'($signed(alu_x)) - longint'($signed(alu_y));
        alu_z = alu_x - alu_y;
        alu_overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: alu_z = ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
      4'd8: alu_z = alu_y >> alu_x[4:0];
      4'd9: alu_z = alu_y << alu_x[4:0];
      4'd10: alu_z = $signed(alu_y) >>> alu_x[4:0];
      default: alu_z = 32'b0;
    endcase
    alu_equal = (alu_x == alu_y);
    alu_zero  = (alu_z == 32'b0);
  end

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [3:0]  op;
    logic        wr, taken, ill, trap;
  } exp_t;

  exp_t exp_q[$];

  function automatic bit ovf(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // Instruction-level reference: what each MIPS instruction must produce
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] sx, zx;
    logic [4:0] sh;
    bit tr;
    longint a, b;
    sx = {{16{i[15]}}, i[15:0]};
    zx = {16'b0, i[15:0]};
    sh = i[10:6];
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    tr = 0;
    e.res = 0; e.op = 4'hF; e.wr = 1; e.taken = 0; e.ill = 0; e.trap = 0;
    e.dest = (i[31:26] == 6'h00) ? i[15:11] : i[20:16];
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h24: begin e.res = rs & rt; e.op = 0; end
        6'h25: begin e.res = rs | rt; e.op = 1; end
        6'h26: begin e.res = rs ^ rt; e.op = 2; end
        6'h27: begin e.res = ~(rs | rt); e.op = 3; end
        6'h20: begin e.res = rs + rt; e.op = 5; tr = ovf(a + b); end
        6'h21: begin e.res = rs + rt; e.op = 5; end
        6'h22: begin e.res = rs - rt; e.op = 6; tr = ovf(a - b); end
        6'h23: begin e.res = rs - rt; e.op = 6; end
        6'h2A: begin e.res = (a < b) ? 1 : 0; e.op = 7; end
        6'h00: begin e.res = rt << sh; e.op = 9; end
        6'h02: begin e.res = rt >> sh; e.op = 8; end
        6'h03: begin e.res = $signed(rt) >>> sh; e.op = 10; end
        default: e.ill = 1;
      endcase
      6'h08: begin
        e.res = rs + sx; e.op = 5;
        tr = ovf(a + longint'($signed(sx)));
      end
      6'h09: begin e.res = rs + sx; e.op = 5; end
      6'h0A: begin
        e.res = (a < longint'($signed(sx))) ? 1 : 0; e.op = 7;
      end
      6'h0C: begin e.res = rs & zx; e.op = 0; end
      6'h0D: begin e.res = rs | zx; e.op = 1; end
      6'h0E: begin e.res = rs ^ zx; e.op = 2; end
      6'h04: begin e.res = rs - rt; e.op = 6; e.wr = 0; e.taken = (rs == rt); end
      6'h05: begin e.res = rs - rt; e.op = 6; e.wr = 0; e.taken = (rs != rt); end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.res = 0; e.op = 4'hF; e.wr = 0; end
`ifdef ALU_CTRL_TRAP_EN
    if (tr) begin e.trap = 1; e.wr = 0; end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // One compare process: every cycle the result is valid, it must match the model
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("result", out_result, exp_q[0].res);
        chk("dest", {27'b0, out_dest}, {27'b0, exp_q[0].dest});
        chk("wr", {31'b0, out_wr}, {31'b0, exp_q[0].wr});
        chk("taken", {31'b0, out_branch_taken}, {31'b0, exp_q[0].taken});
        chk("illegal", {31'b0, out_illegal}, {31'b0, exp_q[0].ill});
        chk("trap", {31'b0, out_trap}, {31'b0, exp_q[0].trap});
        chk("alu_op", {28'b0, alu_op}, {28'b0, exp_q[0].op});
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                      input int hold, input bit lit_en, input logic [31:0] lit);
    int n;
    @(negedge clk);
    instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    exp_q.push_back(model(i, rs, rt));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_valid", {31'b0, out_valid}, 32'd0);
    chk("lat_exec_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", {31'b0, out_valid}, 32'd1);
    if (lit_en) chk("literal_result", out_result, lit);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    exp_t m;
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'hF);
    chk("rst_alu_x", alu_x, 32'd0);
    chk("rst_alu_y", alu_y, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {26'b0, out_dest, out_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(rtype(5'd3, 5'd0, 6'h20), 32'd7, 32'd5, 0, 1, 32'd12);
    m = model(rtype(5'd3, 5'd0, 6'h20), 32'd7, 32'd5);
    chk("model_add_dest", {27'b0, m.dest}, 32'd3);

    send(rtype(5'd4, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1, 0, 1, 32'h80000000);
    send(rtype(5'd4, 5'd0, 6'h21), 32'h7FFFFFFF, 32'd1, 0, 1, 32'h80000000);
    m = model(rtype(5'd4, 5'd0, 6'h21), 32'h7FFFFFFF, 32'd1);
    chk("model_addu_notrap", {31'b0, m.trap}, 32'd0);

    send(itype(6'h04, 5'd2, 16'h0010), 32'h1234, 32'h1234, 0, 1, 32'd0);
    m = model(itype(6'h04, 5'd2, 16'h0010), 32'h1234, 32'h1234);
    chk("model_beq_taken", {31'b0, m.taken}, 32'd1);
    send(itype(6'h05, 5'd2, 16'h0010), 32'h1234, 32'h1234, 1, 0, 32'd0);
    m = model(itype(6'h05, 5'd2, 16'h0010), 32'h1234, 32'h1234);
    chk("model_bne_taken", {31'b0, m.taken}, 32'd0);
    send(itype(6'h05, 5'd2, 16'h0010), 32'h1234, 32'h1235, 0, 1, 32'hFFFFFFFF);

    send(rtype(5'd6, 5'd4, 6'h03), 32'd0, 32'h80000000, 0, 1, 32'hF8000000);
    send(rtype(5'd6, 5'd31, 6'h00), 32'd0, 32'd1, 0, 1, 32'h80000000);
    send(rtype(5'd6, 5'd1, 6'h02), 32'd0, 32'h80000000, 0, 1, 32'h40000000);

    send(itype(6'h0C, 5'd9, 16'hFFFF), 32'hFFFF0F0F, 32'd0, 0, 1, 32'h00000F0F);
    send(itype(6'h0A, 5'd9, 16'hFFFF), 32'hFFFFFFFE, 32'd0, 0, 1, 32'd1);
    send({6'h3F, 26'h0ABCDEF}, 32'd5, 32'd6, 0, 1, 32'd0);
    m = model({6'h3F, 26'h0ABCDEF}, 32'd5, 32'd6);
    chk("model_illegal", {31'b0, m.ill}, 32'd1);
    send(rtype(5'd7, 5'd0, 6'h3F), 32'd5, 32'd6, 0, 1, 32'd0);

    send(rtype(5'd8, 5'd0, 6'h22), 32'h80000000, 32'd1, 0, 1, 32'h7FFFFFFF);
    send(rtype(5'd8, 5'd0, 6'h23), 32'd3, 32'd5, 0, 1, 32'hFFFFFFFE);
    send(rtype(5'd8, 5'd0, 6'h24), 32'hF0F0, 32'hFF00, 0, 1, 32'h0000F000);
    send(rtype(5'd8, 5'd0, 6'h25), 32'hF0F0, 32'hFF00, 0, 1, 32'h0000FFF0);
    send(rtype(5'd8, 5'd0, 6'h26), 32'hF0F0, 32'hFF00, 0, 1, 32'h00000FF0);
    send(rtype(5'd8, 5'd0, 6'h27), 32'hF0F0, 32'hFF00, 0, 1, 32'hFFFF000F);
    send(rtype(5'd8, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 0, 1, 32'd1);
    send(itype(6'h08, 5'd10, 16'h0001), 32'h7FFFFFFF, 32'd0, 0, 1, 32'h80000000);
    send(itype(6'h09, 5'd10, 16'hFFFF), 32'd10, 32'd0, 0, 1, 32'd9);
    send(itype(6'h0D, 5'd11, 16'h8001), 32'h10000000, 32'd0, 0, 1, 32'h10008001);
    send(itype(6'h0E, 5'd11, 16'hFFFF), 32'h0000F0F0, 32'd0, 0, 1, 32'h00000F0F);

    send(rtype(5'd12, 5'd0, 6'h21), 32'd100, 32'd23, 5, 1, 32'd123);

    @(negedge clk);
    instr = rtype(5'd13, 5'd0, 6'h20); rs_data = 32'd1; rt_data = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_exec_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_exec_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_exec_op", {28'b0, alu_op}, 32'hF);
    @(negedge clk);
    rst = 1'b0;
    send(rtype(5'd14, 5'd0, 6'h20), 32'd40, 32'd2, 0, 1, 32'd42);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
